// File: rtl/osmlgd_sched.sv
// Round-robin frame scheduler sharing one decoder between N_REQ requesters; OSMLGD_SCHED_STATS_EN adds counters.
// Latency: accept at T, dec_work at T+1, response one cycle after dec_valid (or TIMEOUT cycles into WAIT).
// Backpressure: one frame in flight; no grants until the response handshakes on rsp_valid & rsp_ready.
module osmlgd_sched #(
  parameter int N_REQ   = 2,
  parameter int W       = 256,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               dec_work,
  output logic [W-1:0]       dec_tx,
  input  logic               dec_free,
  input  logic               dec_valid,
  input  logic [W-1:0]       dec_deout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2:0]         rsp_id,
  output logic [W-1:0]       rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic [15:0]        stat_done,
  output logic [15:0]        stat_tmo
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t        state;
  logic [2:0]    rr_ptr;
  logic [CW-1:0] tmo_cnt;
  logic [7:0]    valid_ext;
  logic [3:0]    cand;
  logic          grant_any;
  logic [2:0]    grant_idx;
  logic [W-1:0]  grant_dat;
  logic          grant;

  assign valid_ext = 8'(req_valid);

  // First valid requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + 4'(i);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (!grant_any && valid_ext[cand[2:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[2:0];
      end
    end
  end

  always_comb begin
    grant_dat = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == 3'(k)) grant_dat = req_data[k*W +: W];
    end
  end

  assign grant     = (state == IDLE) && !rst && dec_free && grant_any;
  assign req_ready = grant ? N_REQ'(8'd1 << grant_idx) : '0;
  assign dec_work  = (state == LAUNCH);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      tmo_cnt  <= '0;
      dec_tx   <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            dec_tx <= grant_dat;
            rsp_id <= grant_idx;
            rr_ptr <= (grant_idx == 3'(N_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
            state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          // A result in the final watchdog cycle still counts as a normal completion.
          if (dec_valid) begin
            rsp_data <= dec_deout;
            rsp_err  <= 1'b0;
            state    <= RESP;
          end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            state    <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OSMLGD_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_done <= '0;
      stat_tmo  <= '0;
    end else if (rsp_valid && rsp_ready) begin
      if (!rsp_err && stat_done != 16'hFFFF) stat_done <= stat_done + 16'd1;
      if (rsp_err && stat_tmo != 16'hFFFF) stat_tmo <= stat_tmo + 16'd1;
    end
  end
`else
  assign stat_done = '0;
  assign stat_tmo  = '0;
`endif

endmodule

// File: tb/tb_osmlgd_sched.sv
// Bench for osmlgd_sched: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_osmlgd_sched;
  localparam int N_REQ = 2;
  localparam int W = 256;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               dec_work;
  logic [W-1:0]       dec_tx;
  logic               dec_free;
  logic               dec_valid;
  logic [W-1:0]       dec_deout;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [2:0]         rsp_id;
  logic [W-1:0]       rsp_data;
  logic               rsp_err;
  logic               busy;
  logic [15:0]        stat_done;
  logic [15:0]        stat_tmo;

  osmlgd_sched #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .dec_work(dec_work), .dec_tx(dec_tx), .dec_free(dec_free),
    .dec_valid(dec_valid), .dec_deout(dec_deout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .stat_done(stat_done), .stat_tmo(stat_tmo)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decoder model: answers ~tx a chosen number of cycles after dec_work.
  int dec_lat = 5;
  bit dec_never = 1'b0;
  bit dec_rand = 1'b0;
  int dv_cyc = -10;
  logic [W-1:0] dec_hold;
  initial begin
    int lat;
    dec_valid = 1'b0;
    dec_deout = '0;
    forever begin
      @(negedge clk);
      if (dec_work === 1'b1 && !dec_never) begin
        lat = dec_rand ? int'($urandom_range(1, 8)) : dec_lat;
        dec_hold = dec_tx;
        repeat (lat) @(negedge clk);
        dec_valid = 1'b1;
        dec_deout = ~dec_hold;
        dv_cyc = cyc;
        @(negedge clk);
        dec_valid = 1'b0;
      end
    end
  end

  function automatic int rr_pick(input int ptr, input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++)
      if (v[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b1; dec_free = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int budget, output int rc);
    rc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (rsp_valid) begin rc = cyc; break; end
    end
    if (rc < 0) chk({tag, "_no_rsp"}, 0, 1);
  endtask

  int t0, rc, bad, bad_rdy, g, m_ptr;
  bit m_busy, prev_rv, drain;
  logic [N_REQ-1:0] exp_rdy;
  logic [W-1:0] pat, s_data;
  logic [2:0] s_id;
  logic s_err;
  int grants[$];
  int ids[$];
  int q_id[$];
  logic [W-1:0] q_dat[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; dec_free = 1'b1; rsp_ready = 1'b1;

    // Reset state
    do_reset(); #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_dec_work", dec_work, 0);
    chk("rst_dec_tx", dec_tx, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields", {rsp_id, rsp_err}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stats", {stat_done, stat_tmo}, 0);

    // 1: single frame, decoder latency 5
    dec_lat = 5;
    @(negedge clk); req_valid = 2'b01; req_data[0 +: W] = W'(1); #1;
    chk("t1_grant", req_ready, 2'b01); t0 = cyc;
    @(negedge clk); req_valid = '0; #1;
    chk("t1_work", dec_work, 1);
    chk("t1_tx", dec_tx, W'(1));
    @(negedge clk); #1;
    chk("t1_work_pulse", dec_work, 0);
    chk("t1_busy", busy, 1);
    wait_rsp("t1", 20, rc);
    chk("t1_lat", rc - t0, 7);
    chk("t1_id", rsp_id, 0);
    chk("t1_data", rsp_data, ~W'(1));
    chk("t1_err", rsp_err, 0);
    @(negedge clk); #1;
    chk("t1_rsp_drop", rsp_valid, 0);
`ifdef OSMLGD_SCHED_STATS_EN
    chk("t1_stat_done", stat_done, 1);
`else
    chk("t1_stat_done", stat_done, 0);
`endif

    // 2: contention, both requesters valid
    do_reset();
    dec_lat = 3; req_valid = 2'b11; bad = 0;
    grants.delete(); ids.delete();
    for (int i = 0; i < 80 && ids.size() < 4; i++) begin
      #1;
      if (req_ready != 0) begin
        if (busy || !$onehot(req_ready)) bad++;
        grants.push_back(req_ready == 2'b10 ? 1 : 0);
        if (grants.size() - ids.size() > 1) bad++;
      end
      if (rsp_valid && rsp_ready) ids.push_back(int'(rsp_id));
      @(negedge clk);
    end
    req_valid = '0;
    chk("t2_ngrant", grants.size(), 4);
    chk("t2_overlap", bad, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t2_grant_seq", (k < grants.size()) ? grants[k] : -1, k % 2);
      chk("t2_rsp_id", (k < ids.size()) ? ids[k] : -1, k % 2);
    end

    // 3: watchdog timeout
    do_reset();
    dec_never = 1'b1;
    @(negedge clk); req_valid = 2'b01; req_data[0 +: W] = rnd_word(); #1;
    chk("t3_grant", req_ready, 2'b01); t0 = cyc;
    @(negedge clk); req_valid = '0;
    wait_rsp("t3", 100, rc);
    chk("t3_lat", rc - (t0 + 2), TIMEOUT);
    chk("t3_err", rsp_err, 1);
    chk("t3_data", rsp_data, 0);
    @(negedge clk); #1;
    dec_never = 1'b0;
`ifdef OSMLGD_SCHED_STATS_EN
    chk("t3_stat_tmo", stat_tmo, 1);
`else
    chk("t3_stat_tmo", stat_tmo, 0);
`endif

    // 4: response backpressure with req1 waiting
    do_reset();
    dec_lat = 2; rsp_ready = 1'b0; pat = rnd_word();
    @(negedge clk); req_valid = 2'b01; req_data[0 +: W] = pat; req_data[W +: W] = ~pat ^ W'(5); #1;
    chk("t4_grant0", req_ready, 2'b01);
    @(negedge clk); req_valid = 2'b10;
    wait_rsp("t4", 20, rc);
    s_id = rsp_id; s_data = rsp_data; s_err = rsp_err;
    chk("t4_data", s_data, ~pat);
    chk("t4_rdy_first", req_ready, 0);
    bad = 0; bad_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 9) rsp_ready = 1'b1;
      #1;
      if (rsp_valid !== 1'b1 || rsp_id !== s_id || rsp_data !== s_data || rsp_err !== s_err) bad++;
      if (req_ready !== '0) bad_rdy++;
    end
    chk("t4_stable", bad, 0);
    chk("t4_no_grant", bad_rdy, 0);
    @(negedge clk); #1;
    chk("t4_grant1", req_ready, 2'b10);
    chk("t4_rsp_gone", rsp_valid, 0);
    @(negedge clk); req_valid = '0;
    wait_rsp("t4b", 20, rc);
    chk("t4_id1", rsp_id, 1);
    chk("t4_data1", rsp_data, pat ^ W'(5));

    // 5: decoder not free
    do_reset();
    @(negedge clk); dec_free = 1'b0; req_valid = 2'b01; bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready !== '0 || dec_work !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("t5_blocked", bad, 0);
    dec_free = 1'b1; #1;
    chk("t5_grant", req_ready, 2'b01);
    @(negedge clk); req_valid = '0;
    wait_rsp("t5", 20, rc);
    chk("t5_id", rsp_id, 0);

    // 6: reset in the middle of WAIT, late result must be ignored
    do_reset();
    dec_lat = 6;
    @(negedge clk); req_valid = 2'b01; req_data[0 +: W] = rnd_word(); #1;
    chk("t6_grant", req_ready, 2'b01);
    @(negedge clk); req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("t6_busy", busy, 0);
    chk("t6_tx", dec_tx, 0);
    chk("t6_outs", {req_ready, dec_work, rsp_valid, rsp_id, rsp_err}, 0);
    chk("t6_data", rsp_data, 0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || dec_work !== 1'b0) bad++;
    end
    chk("t6_ignored", bad, 0);
    @(negedge clk); req_valid = 2'b11; #1;
    chk("t6_ptr0", req_ready, 2'b01);
    @(negedge clk); req_valid = '0;
    wait_rsp("t6", 20, rc);
    chk("t6_id", rsp_id, 0);

    // Randomized traffic against the transaction model
    do_reset();
    dec_rand = 1'b1; m_ptr = 0; m_busy = 1'b0; prev_rv = 1'b0;
    q_id.delete(); q_dat.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drain = (c >= 2950);
      req_valid = drain ? '0 : N_REQ'($urandom);
      for (int k = 0; k < N_REQ; k++) req_data[k*W +: W] = rnd_word();
      dec_free = ($urandom_range(0, 3) != 0);
      rsp_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd_busy", busy, m_busy);
      exp_rdy = '0;
      g = -1;
      if (!m_busy && dec_free && (|req_valid)) begin
        g = rr_pick(m_ptr, req_valid);
        exp_rdy = N_REQ'(1) << g;
      end
      chk("rnd_grant", req_ready, exp_rdy);
      if (g >= 0) begin
        q_id.push_back(g);
        q_dat.push_back(~req_data[g*W +: W]);
        m_ptr = (g + 1) % N_REQ;
        m_busy = 1'b1;
      end
      if (rsp_valid && !prev_rv) chk("rnd_rsp_lat", cyc, dv_cyc + 1);
      prev_rv = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (q_id.size() == 0) chk("rnd_spurious_rsp", 1, 0);
        else begin
          chk("rnd_id", rsp_id, q_id[0]);
          chk("rnd_data", rsp_data, q_dat[0]);
          chk("rnd_err", rsp_err, 0);
          void'(q_id.pop_front());
          void'(q_dat.pop_front());
        end
        m_busy = 1'b0;
      end
    end
    chk("rnd_drained", q_id.size(), 0);
    chk("rnd_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
